// File: rtl/music_pkg.sv
// Shared encodings for the melody sequencer: FSM states, rest code and
// note-ROM field positions.
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_PAUSE
  } state_e;

  localparam logic [3:0] REST_INDEX = 4'd0;

  localparam int DUR_MSB = 7;
  localparam int DUR_LSB = 4;
  localparam int IDX_MSB = 3;
  localparam int IDX_LSB = 0;

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter shared by the sounding and gap phases of a note.
// Load wins over count; the counter parks at zero instead of wrapping.
module note_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign count_o  = cnt_q;
  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a synchronous note ROM, holding each note for dur beats
// (sounding part followed by a short articulation rest), with play/stop/pause/loop.
module melody_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int BEAT_DIV = 1000000,
  parameter int GAP_CYC  = 40000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        note_index,
  output logic              busy,
  output logic              paused,
  output logic              done
);

  localparam int CNT_W = $clog2(15 * BEAT_DIV);
  localparam logic [CNT_W-1:0] BEAT_C = CNT_W'(BEAT_DIV);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_CYC);

  state_e            state_q, state_d;
  state_e            resume_q, resume_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        note_q, note_d;
  logic              busy_q, busy_d;
  logic              paused_q, paused_d;
  logic              done_q, done_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_en;
  logic [CNT_W-1:0]  tmr_count;
  logic              tmr_expire;

  logic [3:0]        dur_w;
  logic [3:0]        idx_w;

  assign dur_w  = rom_data[DUR_MSB:DUR_LSB];
  assign idx_w  = rom_data[IDX_MSB:IDX_LSB];
  assign tmr_en = (state_q == ST_PLAY) || (state_q == ST_GAP);

  note_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .count_o    (tmr_count),
    .expire_o   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      resume_q <= ST_IDLE;
      addr_q   <= '0;
      note_q   <= REST_INDEX;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      addr_q   <= addr_d;
      note_q   <= note_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      done_q   <= done_d;
    end
  end

  // Note index only matters while sounding, so it carries no reset.
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (stop) begin
      state_d  = ST_IDLE;
      addr_d   = '0;
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (play) begin
            state_d = ST_FETCH;
            addr_d  = '0;
          end
        end
        ST_FETCH: begin
          if (pause) begin
            state_d  = ST_PAUSE;
            resume_d = ST_FETCH;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (pause) begin
            state_d  = ST_PAUSE;
            resume_d = ST_FETCH;
          end else if (dur_w != 4'd0) begin
            idx_d    = idx_w;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(dur_w) * BEAT_C - GAP_C;
            state_d  = ST_PLAY;
          end else if (loop_en) begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
        // The cycle a pause arrives still counts; the post-step state is what resumes.
        ST_PLAY: begin
          resume_d = ST_PLAY;
          if (tmr_expire) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_C;
            resume_d = ST_GAP;
          end
          state_d = pause ? ST_PAUSE : resume_d;
        end
        ST_GAP: begin
          resume_d = ST_GAP;
          if (tmr_expire) begin
            addr_d   = addr_q + ADDR_W'(1);
            resume_d = ST_FETCH;
          end
          state_d = pause ? ST_PAUSE : resume_d;
        end
        ST_PAUSE: begin
          if (pause) begin
            state_d = resume_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    note_d   = (state_d == ST_PLAY) ? idx_d : REST_INDEX;
    busy_d   = (state_d != ST_IDLE);
    paused_d = (state_d == ST_PAUSE);
    done_d   = (state_q == ST_LOAD) && !stop && !pause && (dur_w == 4'd0) && !loop_en;
  end

  assign rom_addr   = addr_q;
  assign note_index = note_q;
  assign busy       = busy_q;
  assign paused     = paused_q;
  assign done       = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer with BEAT_DIV=10, GAP_CYC=2 and a 4-entry ROM.
// Each scenario is a table of input events plus expected-output ranges.
module tb_melody_sequencer;

  localparam int ADDR_W   = 2;
  localparam int BEAT_DIV = 10;
  localparam int GAP_CYC  = 2;

  localparam int E_PLAY = 0, E_STOP = 1, E_PAUSE = 2, E_RST = 3;
  localparam int F_NOTE = 0, F_ADDR = 1, F_BUSY = 2, F_PAUSED = 3, F_DONE = 4;

  typedef struct {
    int cyc;
    int sig;
  } ev_t;

  typedef struct {
    int    from;
    int    to;
    int    fld;
    int    val;
    string name;
  } chk_t;

  typedef struct {
    int    fld;
    int    val;
    string name;
    int    cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, play, stop, pause, loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [3:0]        note_index;
  logic              busy, paused, done;

  logic [7:0] rom [4];

  ev_t  evq[$];
  chk_t chkq[$];
  exp_t sb[$];

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  melody_sequencer #(
    .ADDR_W  (ADDR_W),
    .BEAT_DIV(BEAT_DIV),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .play      (play),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_index(note_index),
    .busy      (busy),
    .paused    (paused),
    .done      (done)
  );

  function automatic logic [31:0] get_fld(input int f);
    case (f)
      F_NOTE:   return {28'd0, note_index};
      F_ADDR:   return {30'd0, rom_addr};
      F_BUSY:   return {31'd0, busy};
      F_PAUSED: return {31'd0, paused};
      default:  return {31'd0, done};
    endcase
  endfunction

  task automatic check(input string nm, input int cyc, input int fld, input int want);
    logic [31:0] act;
    act = get_fld(fld);
    ntot++;
    if (act !== want) $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, want);
    else npass++;
  endtask

  task automatic ev(input int c, input int s);
    evq.push_back('{c, s});
  endtask

  task automatic ck(input int f, input int t, input int fld, input int v, input string nm);
    chkq.push_back('{f, t, fld, v, nm});
  endtask

  task automatic song_basic();
    rom[0] = 8'h25; rom[1] = 8'h11; rom[2] = 8'h00; rom[3] = 8'h00;
  endtask

  // Reset, then replay the event table cycle by cycle; expectations for the
  // upcoming cycle go into the scoreboard as stimulus is driven.
  task automatic run_scn(input string scn, input logic le, input int ncyc);
    exp_t e;
    loop_en = le; play = 0; stop = 0; pause = 0; rst = 1;
    @(posedge clk); #1;
    check({scn, "_rst_note"}, -1, F_NOTE, 0);
    check({scn, "_rst_addr"}, -1, F_ADDR, 0);
    check({scn, "_rst_busy"}, -1, F_BUSY, 0);
    check({scn, "_rst_paused"}, -1, F_PAUSED, 0);
    check({scn, "_rst_done"}, -1, F_DONE, 0);
    rst = 0;
    for (int c = 0; c <= ncyc; c++) begin
      play = 0; stop = 0; pause = 0; rst = 0;
      foreach (evq[i]) begin
        if (evq[i].cyc == c) begin
          case (evq[i].sig)
            E_PLAY:  play  = 1;
            E_STOP:  stop  = 1;
            E_PAUSE: pause = 1;
            default: rst   = 1;
          endcase
        end
      end
      foreach (chkq[i]) begin
        if (c + 1 >= chkq[i].from && c + 1 <= chkq[i].to)
          sb.push_back('{chkq[i].fld, chkq[i].val, {scn, "_", chkq[i].name}, c + 1});
      end
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, e.cyc, e.fld, e.val);
      end
    end
    play = 0; stop = 0; pause = 0; rst = 0;
    evq.delete();
    chkq.delete();
  endtask

  initial begin
    rst = 1; play = 0; stop = 0; pause = 0; loop_en = 0;
    song_basic();

    // Basic playback to the end marker
    ev(0, E_PLAY);
    ck(1, 2, F_NOTE, 0, "pre_note");
    ck(3, 20, F_NOTE, 5, "note5");
    ck(21, 22, F_NOTE, 0, "gap0");
    ck(23, 23, F_ADDR, 1, "addr1");
    ck(25, 32, F_NOTE, 1, "note1");
    ck(33, 40, F_NOTE, 0, "tail_note");
    ck(1, 36, F_BUSY, 1, "busy_hi");
    ck(37, 40, F_BUSY, 0, "busy_lo");
    ck(1, 36, F_DONE, 0, "done_lo");
    ck(37, 37, F_DONE, 1, "done_pulse");
    ck(38, 40, F_DONE, 0, "done_after");
    run_scn("basic", 1'b0, 40);

    // Loop back to address 0 on the end marker
    ev(0, E_PLAY);
    ck(35, 36, F_ADDR, 2, "addr2");
    ck(37, 38, F_ADDR, 0, "addr_wrap");
    ck(33, 38, F_NOTE, 0, "rest");
    ck(39, 42, F_NOTE, 5, "note5_again");
    ck(1, 42, F_DONE, 0, "no_done");
    ck(1, 42, F_BUSY, 1, "busy");
    run_scn("loop", 1'b1, 42);

    // Pause mid-note, resume with remaining count
    ev(0, E_PLAY); ev(10, E_PAUSE); ev(30, E_PAUSE);
    ck(3, 10, F_NOTE, 5, "note_before");
    ck(11, 30, F_NOTE, 0, "note_paused");
    ck(11, 30, F_PAUSED, 1, "paused_hi");
    ck(31, 45, F_PAUSED, 0, "paused_lo");
    ck(31, 40, F_NOTE, 5, "note_resumed");
    ck(41, 42, F_NOTE, 0, "gap");
    ck(1, 42, F_ADDR, 0, "addr0");
    ck(43, 43, F_ADDR, 1, "addr1");
    ck(1, 44, F_BUSY, 1, "busy");
    run_scn("pause", 1'b0, 45);

    // Pause during FETCH repeats the fetch on resume
    ev(0, E_PLAY); ev(1, E_PAUSE); ev(5, E_PAUSE);
    ck(2, 5, F_PAUSED, 1, "paused_hi");
    ck(1, 7, F_NOTE, 0, "note0");
    ck(8, 25, F_NOTE, 5, "note5");
    ck(26, 26, F_NOTE, 0, "gap");
    run_scn("pfetch", 1'b0, 27);

    // Pause during GAP freezes the gap count
    ev(0, E_PLAY); ev(21, E_PAUSE); ev(25, E_PAUSE);
    ck(21, 28, F_NOTE, 0, "note0");
    ck(22, 25, F_PAUSED, 1, "paused_hi");
    ck(26, 26, F_ADDR, 0, "addr0");
    ck(27, 27, F_ADDR, 1, "addr1");
    ck(29, 29, F_NOTE, 1, "note1");
    run_scn("pgap", 1'b0, 29);

    // Stop mid-note, then restart
    ev(0, E_PLAY); ev(15, E_STOP); ev(20, E_PLAY);
    ck(16, 22, F_NOTE, 0, "note0");
    ck(16, 16, F_ADDR, 0, "addr0");
    ck(16, 20, F_BUSY, 0, "busy_lo");
    ck(16, 21, F_DONE, 0, "done_lo");
    ck(21, 21, F_BUSY, 1, "busy_hi");
    ck(23, 30, F_NOTE, 5, "note5");
    run_scn("stop", 1'b0, 30);

    // stop beats pause when both arrive together
    ev(0, E_PLAY); ev(12, E_STOP); ev(12, E_PAUSE);
    ck(13, 15, F_PAUSED, 0, "paused_lo");
    ck(13, 15, F_BUSY, 0, "busy_lo");
    ck(13, 15, F_NOTE, 0, "note0");
    run_scn("stoppause", 1'b0, 15);

    // play while playing, and pause while idle, are ignored
    ev(0, E_PLAY); ev(12, E_PLAY); ev(39, E_PAUSE);
    ck(3, 20, F_NOTE, 5, "note5");
    ck(21, 22, F_NOTE, 0, "gap");
    ck(23, 23, F_ADDR, 1, "addr1");
    ck(37, 37, F_DONE, 1, "done");
    ck(40, 41, F_PAUSED, 0, "idle_pause");
    ck(38, 41, F_BUSY, 0, "idle_busy");
    run_scn("ignored", 1'b0, 41);

    // Reset during PAUSE, then play again
    ev(0, E_PLAY); ev(5, E_PAUSE); ev(8, E_RST); ev(10, E_PLAY);
    ck(6, 8, F_PAUSED, 1, "paused_hi");
    ck(9, 9, F_PAUSED, 0, "rst_paused");
    ck(9, 9, F_BUSY, 0, "rst_busy");
    ck(9, 9, F_NOTE, 0, "rst_note");
    ck(9, 9, F_ADDR, 0, "rst_addr");
    ck(9, 9, F_DONE, 0, "rst_done");
    ck(13, 13, F_NOTE, 5, "replay_note");
    run_scn("rstpause", 1'b0, 14);

    // Song without end marker wraps the 2-bit address
    rom[0] = 8'h11; rom[1] = 8'h12; rom[2] = 8'h13; rom[3] = 8'h14;
    ev(0, E_PLAY);
    ck(3, 10, F_NOTE, 1, "n0");
    ck(13, 13, F_ADDR, 1, "a1");
    ck(37, 37, F_ADDR, 3, "a3");
    ck(39, 46, F_NOTE, 4, "n3");
    ck(47, 48, F_NOTE, 0, "gap3");
    ck(49, 50, F_ADDR, 0, "wrap");
    ck(51, 58, F_NOTE, 1, "n0_again");
    ck(1, 58, F_BUSY, 1, "busy");
    run_scn("wrap", 1'b0, 58);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a melody stored in a synchronous note ROM by stepping through entries at a fixed beat rate. Each entry's 4-bit note index is presented to the tone decoder, which converts it into a divider preset; the entry's beat count sets how long the note holds. Sits between the user controls (play, stop, pause, loop) and the tone-decode / speaker-divider datapath. Index 0 is the rest code, so the decoder outputs its silent preset.

## Interface
- ADDR_W, 8: ROM address width; the song holds at most 2^ADDR_W entries.
- BEAT_DIV, 1000000: clock cycles per beat (0.25 s at 4 MHz).
- GAP_CYC, 40000: rest cycles at the end of each note for articulation; BEAT_DIV > GAP_CYC is required.
- clk  in  1  system clock (4 MHz).
- rst  in  1  reset; one clock, synchronous, active-high.
- play  in  1  one-cycle start pulse; honoured only in IDLE.
- stop  in  1  one-cycle pulse; aborts playback from any state.
- pause  in  1  one-cycle pulse; toggles pause while playing.
- loop_en  in  1  level; on end marker, restart at address 0.
- rom_addr  out  ADDR_W  note ROM address.
- rom_data  in  8  {dur[7:4], idx[3:0]}; valid one cycle after rom_addr; dur==0 is the end marker.
- note_index  out  4  to the tone decoder; 0 means rest.
- busy  out  1  high in any state other than IDLE.
- paused  out  1  high while PAUSE is active.
- done  out  1  one-cycle pulse when the song ends without looping.

## Operation
- States:
  - IDLE
  - FETCH: rom_addr is driven.
  - LOAD: rom_data is sampled.
  - PLAY
  - GAP
  - PAUSE: stores the state it was entered from.
- IDLE, play: go to FETCH with rom_addr=0.
- FETCH: go to LOAD unconditionally.
- LOAD:
  - dur≠0: latch idx and dur, load the note counter with dur·BEAT_DIV−GAP_CYC, go to PLAY.
  - dur==0 and loop_en=1: rom_addr←0, go to FETCH.
  - dur==0 and loop_en=0: go to IDLE and pulse done.
- PLAY: note_index=idx; the counter decrements each cycle. At 1, load GAP_CYC and go to GAP.
- GAP: note_index=0; the counter decrements. At 1, rom_addr←rom_addr+1 (wraps from 2^ADDR_W−1 to 0), go to FETCH.
- note_index is 0 in IDLE, FETCH, LOAD, GAP and PAUSE.
- Pause is honoured in FETCH, LOAD, PLAY and GAP:
  - Entering PAUSE freezes the counter and rom_addr and sets paused=1.
  - A second pause pulse resumes the stored state with the counter unchanged.
  - In FETCH or LOAD, the pause takes effect and, on resume, the block re-enters FETCH so the ROM read is repeated.
- Priority of simultaneous pulses: stop > pause > play. play outside IDLE and pause in IDLE are ignored.
- stop, from any state: next cycle is IDLE with rom_addr=0, note_index=0, paused=0, and no done pulse.
- Counter width: ceil(log2(15·BEAT_DIV)) bits. The product is computed once in LOAD; no overflow is permitted.

## Timing
- Reset values: rom_addr=0, note_index=0, busy=0, paused=0, done=0; state IDLE; counter 0.
- Startup latency: play sampled at edge 0 → FETCH at cycle 1 → LOAD at cycle 2 → note_index valid at cycle 3.
- Note period: exactly dur·BEAT_DIV cycles, split into dur·BEAT_DIV−GAP_CYC cycles of sounding and GAP_CYC cycles of rest.
- Inter-note overhead: 2 cycles of rest (FETCH and LOAD).
- Song end: done is high for the single cycle after the LOAD that read the marker; busy falls in that same cycle.
- All outputs are registered. rst overrides everything, including mid-note and PAUSE.

## Structure
- Shared package (music_pkg) holds:
  - state encodings;
  - REST_INDEX = 4'd0;
  - ROM field positions: DUR_MSB=7, DUR_LSB=4, IDX_MSB=3, IDX_LSB=0.
- One sub-module, note_timer: a loadable down-counter with enable (freeze) and an expire flag, instantiated once and shared by PLAY and GAP.
- The ROM and the tone decoder are external; this block only addresses the ROM and drives the index.

## Test plan
All scenarios use BEAT_DIV=10 and GAP_CYC=2. ROM: [0]={2,5}, [1]={1,1}, [2]={0,0}. Play at cycle 0.
- Basic playback: note_index=5 on cycles 3–20 and 0 on 21–22; rom_addr=1 at 23; note_index=1 on 25–32; done pulses at cycle 37 and busy falls at 37.
- Loop: as basic, with loop_en=1 → LOAD of addr 2 at 36, rom_addr=0 at 37, note_index=5 again from cycle 39, and done never pulses.
- Pause: pause at cycle 10, pause again at 30 → note_index=0 and paused=1 for cycles 11–30; note_index=5 resumes at 31 with 10 sounding cycles left and ends at 40.
- Stop: stop at cycle 15 → cycle 16 is IDLE with note_index=0, rom_addr=0, busy=0, done=0. play at 20 → note_index=5 at 23.
- Collisions: stop and pause together at 12 → stop wins and paused stays 0. play at 12 during PLAY → ignored.
- Wrap: ADDR_W=2, ROM has no end marker → after GAP of addr 3, rom_addr=0 and playback continues. rst at any cycle → next cycle matches the reset values.
